// File: rtl/sr_flag_arbiter_pkg.sv
// Shared definitions for the SR flag arbiter: command op encodings and FSM state type.
package sr_flag_arbiter_pkg;

    localparam logic [1:0] OP_NOP    = 2'b00;
    localparam logic [1:0] OP_CLEAR  = 2'b01;
    localparam logic [1:0] OP_SET    = 2'b10;
    localparam logic [1:0] OP_TOGGLE = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_DRIVE = 2'b01,
        ST_CHECK = 2'b10
    } state_t;

endpackage

// File: rtl/sr_flag_arbiter_rr_arbiter.sv
// Round-robin picker: grants the first asserted request at or after the priority pointer.
module rr_arbiter
    import sr_flag_arbiter_pkg::*;
#(
    parameter int unsigned N  = 4,
    parameter int unsigned GW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [GW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [GW-1:0] id
);

    always_comb begin
        logic          found;
        logic [GW-1:0] k;
        grant = '0;
        id    = '0;
        found = 1'b0;
        k     = '0;
        for (int unsigned i = 0; i < N; i++) begin
            k = GW'((32'(ptr) + i) % N);
            if (!found && req[k]) begin
                found    = 1'b1;
                grant[k] = 1'b1;
                id       = k;
            end
        end
    end

endmodule

// File: rtl/sr_flag_arbiter.sv
// Round-robin controller driving a shared bank of SR flip-flops one flag at a time.
// Define SR_FLAG_ARBITER_VERIFY_EN to add a CHECK state that reads Q back after each write.
module sr_flag_arbiter
    import sr_flag_arbiter_pkg::*;
#(
    parameter int unsigned NFLAGS = 8,
    parameter int unsigned NREQ   = 4,
    parameter int unsigned IW     = $clog2(NFLAGS),
    parameter int unsigned GW     = $clog2(NREQ)
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [2*NREQ-1:0]    req_op,
    input  logic [IW*NREQ-1:0]   req_idx,
    output logic [NFLAGS-1:0]    S,
    output logic [NFLAGS-1:0]    R,
    input  logic [NFLAGS-1:0]    Q,
    output logic                 done,
    output logic [GW-1:0]        done_id,
    output logic                 err
);

    state_t            state, state_n;
    logic [GW-1:0]     ptr, ptr_n;
    logic [NREQ-1:0]   grant;
    logic [GW-1:0]     gid;
    logic              any;
    logic [1:0]        op_sel;
    logic [IW-1:0]     idx_sel;
    logic              q_sel;

    logic [IW-1:0]     idx_q, idx_n;
    logic [GW-1:0]     id_q, id_n;
    logic              oor_q, oor_n;
`ifdef SR_FLAG_ARBITER_VERIFY_EN
    logic              exp_q, exp_n;
`endif

    logic [NFLAGS-1:0] s_n, r_n;
    logic              done_n, err_n;
    logic [GW-1:0]     done_id_n;

    // Out-of-range indices decode to an all-zero vector, which makes them behave as NOP.
    function automatic logic [NFLAGS-1:0] flag_onehot(input logic [IW-1:0] i);
        logic [NFLAGS-1:0] v;
        v = '0;
        for (int unsigned f = 0; f < NFLAGS; f++) begin
            v[f] = (32'(i) == f);
        end
        return v;
    endfunction

    function automatic logic flag_bit(input logic [NFLAGS-1:0] v, input logic [IW-1:0] i);
        return |(v & flag_onehot(i));
    endfunction

    rr_arbiter #(
        .N  (NREQ),
        .GW (GW)
    ) u_rr (
        .req   (req_valid),
        .ptr   (ptr),
        .grant (grant),
        .id    (gid)
    );

    assign any       = |grant;
    assign req_ready = (state == ST_IDLE) ? grant : '0;

    always_comb begin
        op_sel  = OP_NOP;
        idx_sel = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (gid == GW'(i)) begin
                op_sel  = req_op[2*i +: 2];
                idx_sel = req_idx[IW*i +: IW];
            end
        end
    end

    always_comb begin
        state_n   = state;
        ptr_n     = ptr;
        idx_n     = idx_q;
        id_n      = id_q;
        oor_n     = oor_q;
`ifdef SR_FLAG_ARBITER_VERIFY_EN
        exp_n     = exp_q;
`endif
        s_n       = '0;
        r_n       = '0;
        done_n    = 1'b0;
        err_n     = 1'b0;
        done_id_n = done_id;
        q_sel     = flag_bit(Q, idx_sel);

        case (state)
            ST_IDLE: begin
                if (any) begin
                    idx_n   = idx_sel;
                    id_n    = gid;
                    oor_n   = !(32'(idx_sel) < NFLAGS);
                    ptr_n   = (gid == GW'(NREQ - 1)) ? '0 : gid + GW'(1);
                    state_n = ST_DRIVE;
                    case (op_sel)
                        OP_SET:    s_n = flag_onehot(idx_sel);
                        OP_CLEAR:  r_n = flag_onehot(idx_sel);
                        OP_TOGGLE: begin
                            if (q_sel) r_n = flag_onehot(idx_sel);
                            else       s_n = flag_onehot(idx_sel);
                        end
                        default: ;
                    endcase
`ifdef SR_FLAG_ARBITER_VERIFY_EN
                    case (op_sel)
                        OP_SET:    exp_n = 1'b1;
                        OP_CLEAR:  exp_n = 1'b0;
                        OP_TOGGLE: exp_n = ~q_sel;
                        default:   exp_n = q_sel;
                    endcase
`endif
                end
            end
            ST_DRIVE: begin
`ifdef SR_FLAG_ARBITER_VERIFY_EN
                state_n   = ST_CHECK;
`else
                state_n   = ST_IDLE;
                done_n    = 1'b1;
                err_n     = oor_q;
                done_id_n = id_q;
`endif
            end
`ifdef SR_FLAG_ARBITER_VERIFY_EN
            ST_CHECK: begin
                state_n   = ST_IDLE;
                done_n    = 1'b1;
                err_n     = oor_q | (flag_bit(Q, idx_q) != exp_q);
                done_id_n = id_q;
            end
`endif
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state   <= ST_IDLE;
            ptr     <= '0;
            idx_q   <= '0;
            id_q    <= '0;
            oor_q   <= 1'b0;
`ifdef SR_FLAG_ARBITER_VERIFY_EN
            exp_q   <= 1'b0;
`endif
            S       <= '0;
            R       <= '0;
            done    <= 1'b0;
            err     <= 1'b0;
            done_id <= '0;
        end else begin
            state   <= state_n;
            ptr     <= ptr_n;
            idx_q   <= idx_n;
            id_q    <= id_n;
            oor_q   <= oor_n;
`ifdef SR_FLAG_ARBITER_VERIFY_EN
            exp_q   <= exp_n;
`endif
            S       <= s_n;
            R       <= r_n;
            done    <= done_n;
            err     <= err_n;
            done_id <= done_id_n;
        end
    end

endmodule

// File: tb/tb_sr_flag_arbiter.sv
// Bench for sr_flag_arbiter: transaction-level reference model plus a behavioural SR bank.
module tb_sr_flag_arbiter;
    import sr_flag_arbiter_pkg::*;

    localparam int NF = 8;
    localparam int NQ = 4;
    localparam int IWB = 4;
    localparam int GWB = 2;
`ifdef SR_FLAG_ARBITER_VERIFY_EN
    localparam int LAT = 3;
    localparam bit VERIFY = 1'b1;
`else
    localparam int LAT = 2;
    localparam bit VERIFY = 1'b0;
`endif

    logic             CLK = 1'b0;
    logic             RST_N = 1'b0;
    logic [NQ-1:0]    req_valid = '0;
    logic [NQ-1:0]    req_ready;
    logic [2*NQ-1:0]  req_op = '0;
    logic [IWB*NQ-1:0] req_idx = '0;
    logic [NF-1:0]    S, R;
    logic [NF-1:0]    Q = '0;
    logic             done, err;
    logic [GWB-1:0]   done_id;
    logic [NF-1:0]    stuck0 = '0;

    sr_flag_arbiter #(
        .NFLAGS (NF),
        .NREQ   (NQ),
        .IW     (IWB),
        .GW     (GWB)
    ) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_idx   (req_idx),
        .S         (S),
        .R         (R),
        .Q         (Q),
        .done      (done),
        .done_id   (done_id),
        .err       (err)
    );

    always #5 CLK = ~CLK;

    // Behavioural SR bank sharing the DUT clock; stuck0 forces bits low.
    always @(posedge CLK) Q <= ((Q | S) & ~R) & ~stuck0;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: one outstanding command, completion LAT cycles after acceptance.
    int          m_ptr = 0;
    bit          pend = 0;
    int          pcnt = 0;
    int          p_id = 0;
    logic [3:0]  p_idx;
    bit          p_oor, p_exp, p_bad;
    logic [NF-1:0] p_s, p_r;

    logic [NF-1:0] s_or, r_or;
    bit          done_seen, done_err;
    logic [GWB-1:0] done_id_seen;
    logic [NQ-1:0] last_ready;
    int          obs_grants[$];

    task automatic model_step();
        logic [NF-1:0] es, er;
        logic [NQ-1:0] erdy;
        bit edone, eerr;
        int win;
        logic [1:0] op;
        logic [3:0] idx;
        bit qv;
        es = '0; er = '0; erdy = '0; edone = 0; eerr = 0; win = -1;

        s_or |= S;
        r_or |= R;
        last_ready = req_ready;
        if (done) begin
            done_seen = 1; done_err = err; done_id_seen = done_id;
        end
        for (int k = 0; k < NQ; k++) if (req_ready[k]) obs_grants.push_back(k);

        if (!RST_N) begin
            pend = 0; m_ptr = 0;
            check_eq("rst_S", S, 0);
            check_eq("rst_R", R, 0);
            check_eq("rst_ready", req_ready, 0);
            check_eq("rst_done", done, 0);
            check_eq("rst_err", err, 0);
            check_eq("rst_done_id", done_id, 0);
            return;
        end

        if (pend) begin
            pcnt++;
            if (pcnt == 1) begin es = p_s; er = p_r; end
            if (pcnt == 2 && !p_oor) p_bad = (Q[p_idx[2:0]] != p_exp);
            if (pcnt == LAT) begin
                edone = 1;
                eerr  = p_oor || (VERIFY && p_bad);
                pend  = 0;
                check_eq("done_id", done_id, p_id);
            end
        end
        check_eq("S", S, es);
        check_eq("R", R, er);
        check_eq("done", done, edone);
        check_eq("err", err, eerr);
        check_eq("s_and_r", S & R, 0);
        check_eq("sr_onehot", ($countones(S | R) <= 1), 1);

        if (!pend) begin
            for (int k = 0; k < NQ; k++) begin
                int j;
                j = (m_ptr + k) % NQ;
                if (win < 0 && req_valid[j]) win = j;
            end
        end
        if (win >= 0) begin
            erdy[win] = 1'b1;
            op    = req_op[2*win +: 2];
            idx   = req_idx[IWB*win +: IWB];
            p_oor = (idx >= NF);
            p_idx = idx;
            qv    = p_oor ? 1'b0 : Q[idx[2:0]];
            p_s = '0; p_r = '0; p_bad = 0;
            case (op)
                OP_SET:    begin p_exp = 1; if (!p_oor) p_s[idx[2:0]] = 1'b1; end
                OP_CLEAR:  begin p_exp = 0; if (!p_oor) p_r[idx[2:0]] = 1'b1; end
                OP_TOGGLE: begin
                    p_exp = !qv;
                    if (!p_oor) begin
                        if (qv) p_r[idx[2:0]] = 1'b1;
                        else    p_s[idx[2:0]] = 1'b1;
                    end
                end
                default:   p_exp = qv;
            endcase
            pend = 1; pcnt = 0; p_id = win;
            m_ptr = (win + 1) % NQ;
        end
        check_eq("ready", req_ready, erdy);
    endtask

    task automatic step();
        @(negedge CLK);
        #1;
        model_step();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_req(input int i, input bit v, input logic [1:0] op, input logic [3:0] idx);
        req_valid[i] = v;
        req_op[2*i +: 2] = op;
        req_idx[IWB*i +: IWB] = idx;
    endtask

    task automatic do_reset();
        req_valid = '0;
        RST_N = 1'b0;
        step();
        step();
        RST_N = 1'b1;
    endtask

    task automatic run_cmd(input int id, input logic [1:0] op, input logic [3:0] idx);
        bit hs;
        hs = 0;
        req_valid = '0;
        set_req(id, 1, op, idx);
        s_or = '0; r_or = '0; done_seen = 0; done_err = 0; done_id_seen = '0;
        for (int k = 0; k < 12 && !hs; k++) begin
            step();
            hs = last_ready[id];
        end
        check_eq("handshake_timeout", hs, 1);
        req_valid = '0;
        repeat (LAT) step();
    endtask

    initial begin
        int exp_g[5];
        exp_g = '{0, 1, 2, 3, 0};

        // Reset, then SET idx 3 from requester 0
        do_reset();
        run_cmd(0, OP_SET, 4'd3);
        check_eq("t1_S_pulse", s_or, 8'h08);
        check_eq("t1_R_pulse", r_or, 0);
        check_eq("t1_done", done_seen, 1);
        check_eq("t1_done_id", done_id_seen, 0);
        check_eq("t1_err", done_err, 0);
        check_eq("t1_Q3", Q[3], 1);

        // All requesters valid, each targeting its own id
        do_reset();
        obs_grants.delete();
        for (int i = 0; i < NQ; i++) set_req(i, 1, OP_SET, 4'(i));
        for (int k = 0; k < 5*LAT; k++) begin
            step();
            for (int i = 0; i < NQ; i++) req_op[2*i +: 2] = 2'($urandom_range(0, 3));
        end
        req_valid = '0;
        repeat (LAT) step();
        check_eq("rr_count", (obs_grants.size() >= 5), 1);
        for (int k = 0; k < 5; k++)
            if (k < obs_grants.size()) check_eq("rr_order", obs_grants[k], exp_g[k]);

        // TOGGLE idx 5 twice from a known-zero start
        run_cmd(1, OP_CLEAR, 4'd5);
        check_eq("tg_pre_Q5", Q[5], 0);
        run_cmd(2, OP_TOGGLE, 4'd5);
        check_eq("tg1_S", s_or, 8'h20);
        check_eq("tg1_R", r_or, 0);
        check_eq("tg1_err", done_err, 0);
        check_eq("tg1_Q5", Q[5], 1);
        run_cmd(2, OP_TOGGLE, 4'd5);
        check_eq("tg2_S", s_or, 0);
        check_eq("tg2_R", r_or, 8'h20);
        check_eq("tg2_err", done_err, 0);
        check_eq("tg2_Q5", Q[5], 0);

        // Stuck-at-zero flag 2, then SET it
        stuck0 = 8'h04;
        step();
        run_cmd(3, OP_SET, 4'd2);
        check_eq("stuck_done", done_seen, 1);
        check_eq("stuck_err", done_err, VERIFY);
        stuck0 = '0;

        // Out-of-range index
        run_cmd(0, OP_SET, 4'd9);
        check_eq("oor_S", s_or, 0);
        check_eq("oor_R", r_or, 0);
        check_eq("oor_done", done_seen, 1);
        check_eq("oor_err", done_err, 1);

        // Reset asserted while DRIVE is active
        do_reset();
        run_cmd(0, OP_CLEAR, 4'd1);
        req_valid = '0;
        set_req(2, 1, OP_SET, 4'd1);
        step();
        check_eq("mid_hs", last_ready, 4'b0100);
        req_valid = '0;
        check_eq("mid_S_before", S, 8'h02);
        RST_N = 1'b0;
        #1;
        check_eq("mid_S_async", S, 0);
        check_eq("mid_R_async", R, 0);
        step();
        RST_N = 1'b1;
        done_seen = 0;
        repeat (LAT + 1) step();
        check_eq("mid_no_done", done_seen, 0);
        obs_grants.delete();
        for (int i = 0; i < NQ; i++) set_req(i, 1, OP_NOP, 4'(i));
        step();
        check_eq("mid_next_grant_cnt", obs_grants.size(), 1);
        if (obs_grants.size() > 0) check_eq("mid_next_grant", obs_grants[0], 0);
        req_valid = '0;
        repeat (LAT) step();

        // Randomised traffic, including out-of-range indices and dropped requests
        for (int k = 0; k < 400; k++) begin
            for (int i = 0; i < NQ; i++)
                set_req(i, bit'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                        4'($urandom_range(0, 9)));
            step();
        end
        req_valid = '0;
        repeat (LAT + 1) step();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
